// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB first, one bit per clk.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (a - b, cout=1 means no borrow).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic c,
    output logic cout
);
    assign c    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sh_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic w_fa_b;
    logic w_fa_c;
    logic w_fa_cout;

`ifdef SERIAL_ADD_SUB_EN
    logic r_sub;
    // Subtract as a + ~b + 1: invert B here, carry preloaded with 1 at start.
    assign w_fa_b = r_sh_b[0] ^ r_sub;
`else
    assign w_fa_b = r_sh_b[0];
`endif

    full_adder u_fa (
        .a    (r_sh_a[0]),
        .b    (w_fa_b),
        .cin  (r_carry),
        .c    (w_fa_c),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_s  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                        r_sub   <= sub;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_carry <= cin;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_fa_cout;
                    r_sh_s  <= {w_fa_c, r_sh_s[WIDTH-1:1]};
                    r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
                    if (r_cnt == CNT_LAST) begin
                        // Last bit: publish the finished word as DONE is entered.
                        r_cnt   <= '0;
                        r_sum   <= {w_fa_c, r_sh_s[WIDTH-1:1]};
                        r_cout  <= w_fa_cout;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: time-multiplexes one instance of the team's 1-bit full_adder cell (ports a, b, cin, c = sum bit, cout) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Carry is held in a flip-flop between bits.
- Start/busy/done handshake toward the requester; the result is registered and held until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits (min 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  initial carry-in, captured when start is accepted
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  registered result
cout  output  1  registered final carry-out

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-low reset (rst_n).
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter=0.
- States and transitions:
  - IDLE: start=1 -> load sh_a=a, sh_b=b, carry=cin, cnt=0; next RUN.
  - RUN: full_adder inputs are sh_a[0], sh_b[0], carry.
    - Each cycle: carry<=fa.cout; fa.c is shifted into sh_s at the MSB (sh_s shifts right); sh_a and sh_b shift right; cnt++.
    - When cnt==WIDTH-1: next DONE.
  - DONE: sum<=sh_s, cout<=carry, done=1 for exactly this cycle; next IDLE unconditionally.
- Timing: start sampled at edge 0 -> RUN for WIDTH cycles -> done high in cycle WIDTH+1 (WIDTH=8: done 9 cycles after the accepting edge).
- busy=1 exactly while state==RUN (combinational decode of state).
- Output stability: sum/cout update only on DONE entry and hold their previous values throughout RUN.
- start while RUN or DONE: ignored, no queuing. start held high continuously: a new operation begins on the IDLE cycle after DONE.
- Operands and cin changing after acceptance: no effect on the operation in flight.
- Arithmetic: result is (a+b+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum.
- cnt width: $clog2(WIDTH) bits. cnt wraps to 0 at DONE.
- rst_n low mid-RUN: immediate abort to reset values; partial result discarded; no done pulse.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1: B bits are inverted at the full_adder b input and the carry is preloaded with 1 (cin ignored). Result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - sub=0: behaviour identical to the undefined case.
- Undefined: port sub absent; add only.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulsed -> busy high 8 cycles, done pulse in cycle 9, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Run a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF in RUN cycle 4 -> ignored; result 0x30, cout=0; sum holds its previous value until done.
- rst_n low in RUN cycle 3 of a=0x77, b=0x11 -> busy, done, sum, cout immediately 0; no done pulse; next start with a=0x01, b=0x02 -> sum=0x03.
- SERIAL_ADD_SUB_EN defined, sub=1:
  - a=0x05, b=0x07 -> sum=0xFE, cout=0.
  - a=0x07, b=0x05 -> sum=0x02, cout=1.
- start held high continuously, a=0x01, b=0x01 -> done pulses every WIDTH+2=10 cycles, each with sum=0x02.
